// File: rtl/mux8way_arbiter_pkg.sv
// Shared constants for the 8-way gathering arbiter: channel count, sel width,
// FSM state encoding and channel-index names matching the 8-way demux sel.
package mux8way_arbiter_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] CH_A = 3'd0;
    localparam logic [SEL_W-1:0] CH_B = 3'd1;
    localparam logic [SEL_W-1:0] CH_C = 3'd2;
    localparam logic [SEL_W-1:0] CH_D = 3'd3;
    localparam logic [SEL_W-1:0] CH_E = 3'd4;
    localparam logic [SEL_W-1:0] CH_F = 3'd5;
    localparam logic [SEL_W-1:0] CH_G = 3'd6;
    localparam logic [SEL_W-1:0] CH_H = 3'd7;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/mux8way_arbiter_rr_pick8.sv
// Rotating-priority finder: returns the first set request bit searching
// ptr+1, ptr+2, ... ptr (mod 8).
module mux8way_arbiter_rr_pick8
    import mux8way_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [SEL_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest request after ptr wins.
    always_comb begin
        gnt_idx = 3'd0;
        gnt_any = 1'b0;
        w_idx   = 3'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = ptr + SEL_W'(k);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_any = 1'b1;
            end else begin
                gnt_idx = gnt_idx;
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/mux8way_arbiter.sv
// 8-to-1 round-robin gathering arbiter with a registered output slice.
// Each output word carries the 3-bit source index (demux sel encoding).
// Optional feature macro: MUX8WAY_ARBITER_LOCK_EN adds in_lock, which pins
// the grant to a channel until one of its words arrives with lock cleared.
module mux8way_arbiter
    import mux8way_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef MUX8WAY_ARBITER_LOCK_EN
    input  logic [NUM_CH-1:0]       in_lock,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_e           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;

    logic [NUM_CH-1:0] w_req;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_gnt_any;
    logic              w_slot_free;
    logic              w_grant;
    logic [WIDTH-1:0]  w_word;

`ifdef MUX8WAY_ARBITER_LOCK_EN
    logic             r_lock_active;
    logic [SEL_W-1:0] r_lock_ch;

    // While locked only the owning channel may be granted.
    assign w_req = r_lock_active ? (in_valid & onehot8(r_lock_ch)) : in_valid;
`else
    assign w_req = in_valid;
`endif

    mux8way_arbiter_rr_pick8 u_pick (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign out_valid   = (r_state == ST_FULL);
    assign out_data    = r_data;
    assign out_sel     = r_sel;
    assign w_slot_free = (r_state == ST_EMPTY) | out_ready;
    assign w_grant     = w_slot_free & w_gnt_any;
    assign w_word      = in_data[w_gnt_idx*WIDTH +: WIDTH];

    // in_ready is forced low during reset so no source sees a phantom accept.
    assign in_ready = (rst_n && w_grant) ? onehot8(w_gnt_idx) : 8'h00;

    // Slot FSM: refill on grant, drain to EMPTY when consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= CH_H;
            r_data  <= {WIDTH{1'b0}};
            r_sel   <= CH_A;
`ifdef MUX8WAY_ARBITER_LOCK_EN
            r_lock_active <= 1'b0;
            r_lock_ch     <= CH_A;
`endif
        end else begin
            case (r_state)
                ST_EMPTY, ST_FULL: begin
                    if (w_grant) begin
                        r_state <= ST_FULL;
                        r_data  <= w_word;
                        r_sel   <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx;
`ifdef MUX8WAY_ARBITER_LOCK_EN
                        r_lock_active <= in_lock[w_gnt_idx];
                        r_lock_ch     <= w_gnt_idx;
`endif
                    end else if (out_ready) begin
                        r_state <= ST_EMPTY;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Self-checking bench for mux8way_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mux8way_arbiter;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_ready;
    logic [7:0]   in_lock;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic         out_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    logic        m_valid;
    logic [15:0] m_data;
    logic [2:0]  m_sel;
    int          m_ptr;
    logic        m_lock;
    int          m_lock_ch;
    logic [7:0]  last_acc;

    mux8way_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MUX8WAY_ARBITER_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requesting channel scanning ptr+1 .. ptr+8.
    function automatic int exp_gidx();
        int ch;
        exp_gidx = -1;
        if (rst_n === 1'b1 && (!m_valid || out_ready)) begin
            for (int k = 1; k <= 8; k++) begin
                ch = (m_ptr + k) % 8;
                if (exp_gidx < 0 && in_valid[ch] && (!m_lock || ch == m_lock_ch))
                    exp_gidx = ch;
            end
        end
    endfunction

    function automatic logic [7:0] exp_ready();
        int g;
        logic [7:0] r;
        g = exp_gidx();
        r = 8'h00;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Model update at each rising edge (async reset).
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= 16'h0000;
            m_sel     <= 3'd0;
            m_ptr     <= 7;
            m_lock    <= 1'b0;
            m_lock_ch <= 0;
            last_acc  <= 8'h00;
        end else begin
            g = exp_gidx();
            last_acc <= exp_ready();
            if (g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= in_data[g*16 +: 16];
                m_sel   <= 3'(g);
                m_ptr   <= g;
`ifdef MUX8WAY_ARBITER_LOCK_EN
                m_lock    <= in_lock[g];
                m_lock_ch <= g;
`endif
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, DUT vs model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  {24'h0, in_ready},  {24'h0, exp_ready()});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            chk("out_data",  {16'h0, out_data},  {16'h0, m_data});
            chk("out_sel",   {29'h0, out_sel},   {29'h0, m_sel});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        in_lock   = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'h1000 + 16'(i);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {24'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data}, 32'h0);
        chk("rst_out_sel",   {29'h0, out_sel}, 32'h0);
        #2 rst_n = 1'b1;
        #1 chk("first_grant", {24'h0, in_ready}, 32'h01);
        cmp_en = 1'b1;

        // rotation 0..7,0 with no bubbles
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rot_valid", {31'h0, out_valid}, 32'h1);
            chk("rot_sel",   {29'h0, out_sel}, 32'(i % 8));
            chk("rot_data",  {16'h0, out_data}, 32'h1000 + 32'(i % 8));
        end

        // reset mid-stream between edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_ready", {24'h0, in_ready}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("restart_grant", {24'h0, in_ready}, 32'h01);

        // single requester on channel 5
        step();
        in_valid = 8'h20;
        in_data[5*16 +: 16] = 16'hBEEF;
        @(negedge clk);
        chk("single_ready0", {24'h0, in_ready}, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("single_ready", {24'h0, in_ready}, 32'h20);
            chk("single_sel",   {29'h0, out_sel}, 32'h5);
            chk("single_data",  {16'h0, out_data}, 32'h0000BEEF);
        end

        // backpressure: hold word from channel 3 while 4 and 6 wait
        step();
        in_valid = 8'h08;
        step();
        in_valid  = 8'h50;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", {24'h0, in_ready}, 32'h0);
            chk("bp_sel",   {29'h0, out_sel}, 32'h3);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", {24'h0, in_ready}, 32'h10);
        step();
        in_valid = 8'h40;
        @(negedge clk);
        chk("bp_sel4", {29'h0, out_sel}, 32'h4);
        chk("bp_ready6", {24'h0, in_ready}, 32'h40);
        step();
        in_valid = 8'h00;
        @(negedge clk);
        chk("bp_sel6", {29'h0, out_sel}, 32'h6);
        step();
        @(negedge clk);
        chk("bp_drain", {31'h0, out_valid}, 32'h0);

        // drain to empty and wrap: ptr=7, one word on channel 0, then 7
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        in_valid = 8'h01;
        @(negedge clk);
        chk("wrap_ready0", {24'h0, in_ready}, 32'h01);
        step();
        in_valid = 8'h00;
        @(negedge clk);
        chk("wrap_sel0", {29'h0, out_sel}, 32'h0);
        step();
        @(negedge clk);
        chk("wrap_empty", {31'h0, out_valid}, 32'h0);
        step();
        in_valid = 8'h80;
        @(negedge clk);
        chk("wrap_ready7", {24'h0, in_ready}, 32'h80);
        step();
        in_valid = 8'h00;
        @(negedge clk);
        chk("wrap_sel7", {29'h0, out_sel}, 32'h7);

        // randomized traffic; sources hold words until the model accepts them
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            for (int c = 0; c < 8; c++) begin
                if (last_acc[c]) in_valid[c] = 1'b0;
                if (!in_valid[c] && ($urandom % 3 == 0)) begin
                    in_valid[c] = 1'b1;
                    in_data[c*16 +: 16] = 16'($urandom);
`ifdef MUX8WAY_ARBITER_LOCK_EN
                    in_lock[c] = ($urandom % 4 == 0);
`endif
                end
            end
            out_ready = ($urandom % 10 < 7);
            if (cyc == 2000) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
